// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment display scanner: shadowed digit data, per-digit
// enable, hex/decimal decode, leading-zero blanking and PWM brightness.
module seven_seg_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT_LOG2  = 9,
    parameter int BRIGHT_W   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] dig_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    input  logic                    hex_mode,
    input  logic                    lz_blank,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [7:0]              sg_out,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [SLOT_LOG2-1:0]    slot_cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow_dig;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    logic                    slot_wrap;
    logic                    pwm_on;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_en;
    logic                    cur_lz;
    logic                    all_zero;
    logic [NUM_DIGITS-1:0]   lz_vec;
    logic                    blank;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [7:0]              sg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    seg_decode = 7'b1000000;
            4'h1:    seg_decode = 7'b1111001;
            4'h2:    seg_decode = 7'b0100100;
            4'h3:    seg_decode = 7'b0110000;
            4'h4:    seg_decode = 7'b0011001;
            4'h5:    seg_decode = 7'b0010010;
            4'h6:    seg_decode = 7'b0000010;
            4'h7:    seg_decode = 7'b1111000;
            4'h8:    seg_decode = 7'b0000000;
            4'h9:    seg_decode = 7'b0010000;
            4'hA:    seg_decode = 7'b0001000;
            4'hB:    seg_decode = 7'b0000011;
            4'hC:    seg_decode = 7'b1000110;
            4'hD:    seg_decode = 7'b0100001;
            4'hE:    seg_decode = 7'b0000110;
            default: seg_decode = 7'b0001110;
        endcase
    endfunction

    assign slot_wrap = &slot_cnt;
    assign pwm_on    = (slot_cnt[SLOT_LOG2-1 -: BRIGHT_W] <= brightness);

    // lz_vec[i] is set when digit i and every more-significant digit are zero
    always_comb begin
        all_zero = 1'b1;
        lz_vec   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero  = all_zero & (shadow_dig[4*i +: 4] == 4'h0);
            lz_vec[i] = all_zero;
        end
    end

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        cur_lz  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib = shadow_dig[4*i +: 4];
                cur_dp  = shadow_dp[i];
                cur_en  = en_in[i];
                cur_lz  = lz_vec[i];
            end
        end
    end

    always_comb begin
        an_next = '1;
        sg_next = 8'hFF;
        blank   = (lz_blank && cur_lz && (idx != '0)) || (!hex_mode && (cur_nib > 4'd9));
        if (cur_en && pwm_on) begin
            an_next = ~(NUM_DIGITS'(1) << idx);
            sg_next = {~cur_dp, blank ? 7'h7F : seg_decode(cur_nib)};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_cnt   <= '0;
            idx        <= '0;
            shadow_dig <= '0;
            shadow_dp  <= '0;
            an_out     <= '1;
            sg_out     <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            slot_cnt   <= slot_cnt + 1'b1;
            if (slot_wrap)
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            frame_done <= slot_wrap && (idx == LAST_IDX);
            if (load) begin
                shadow_dig <= dig_in;
                shadow_dp  <= dp_in;
            end
            an_out     <= an_next;
            sg_out     <= sg_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with 4 digits, 16-cycle slots and
// 2-bit brightness; expected patterns are hand-decoded constants.
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] dig_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  en_in = 4'hF;
    logic        hex_mode = 1'b1;
    logic        lz_blank = 1'b0;
    logic [1:0]  brightness = 2'd3;
    logic [3:0]  an_out;
    logic [7:0]  sg_out;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;   // active edges since reset release

    seven_seg_scanner #(.NUM_DIGITS(4), .SLOT_LOG2(4), .BRIGHT_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .dig_in     (dig_in),
        .dp_in      (dp_in),
        .en_in      (en_in),
        .hex_mode   (hex_mode),
        .lz_blank   (lz_blank),
        .brightness (brightness),
        .an_out     (an_out),
        .sg_out     (sg_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stop on the negedge whose outputs reflect digit d, slot s
    task automatic wait_pos(input int d, input int s);
        bit found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (cyc > 0 && ((cyc - 1) % 64) == d * 16 + s) found = 1;
        end
        if (!found) check("wait_pos_timeout", 0, 1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        @(negedge clk);
        dig_in = d;
        dp_in  = p;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic count_lit(input int d, output int lit);
        lit = 0;
        wait_pos(d, 0);
        for (int i = 0; i < 16; i++) begin
            if (an_out != 4'hF) lit++;
            if (i != 15) @(negedge clk);
        end
    endtask

    initial begin
        int lit;
        int pulses;
        int bad_pos;

        // power-up reset
        repeat (3) @(negedge clk);
        check("por_an", an_out, 4'hF);
        check("por_sg", sg_out, 8'hFF);
        reset = 1'b1;
        @(negedge clk);
        check("release_an", an_out, 4'b1110);

        // scan 0x1234
        do_load(16'h1234, 4'b0000);
        wait_pos(0, 5); check("scan_an0", an_out, 4'b1110); check("scan_sg0", sg_out, 8'h99);
        wait_pos(1, 5); check("scan_an1", an_out, 4'b1101); check("scan_sg1", sg_out, 8'hB0);
        wait_pos(2, 5); check("scan_an2", an_out, 4'b1011); check("scan_sg2", sg_out, 8'hA4);
        wait_pos(3, 5); check("scan_an3", an_out, 4'b0111); check("scan_sg3", sg_out, 8'hF9);

        // frame_done spacing over two frames
        pulses  = 0;
        bad_pos = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if (frame_done) begin
                pulses++;
                if ((cyc % 64) != 0) bad_pos++;
            end
        end
        check("frame_pulses", pulses, 2);
        check("frame_pos", bad_pos, 0);

        // mid-scan reset with load held (must be ignored)
        wait_pos(2, 7);
        reset  = 1'b0;
        load   = 1'b1;
        dig_in = 16'h8888;
        repeat (5) @(negedge clk);
        check("rst_an", an_out, 4'hF);
        check("rst_sg", sg_out, 8'hFF);
        check("rst_fd", frame_done, 1'b0);
        reset = 1'b1;
        load  = 1'b0;
        @(negedge clk);
        check("rst_rel_an", an_out, 4'b1110);
        check("rst_rel_sg", sg_out, 8'hC0);

        // hex vs decimal
        do_load(16'h00AF, 4'b0000);
        wait_pos(0, 5); check("hex_sg0", sg_out, 8'h8E);
        wait_pos(1, 5); check("hex_sg1", sg_out, 8'h88);
        hex_mode = 1'b0;
        wait_pos(0, 5); check("dec_an0", an_out, 4'b1110); check("dec_sg0", sg_out, 8'hFF);
        wait_pos(1, 5); check("dec_an1", an_out, 4'b1101); check("dec_sg1", sg_out, 8'hFF);
        hex_mode = 1'b1;

        // leading-zero blanking with a dp on a blanked digit
        lz_blank = 1'b1;
        do_load(16'h0005, 4'b0100);
        wait_pos(3, 5); check("lz_an3", an_out, 4'b0111); check("lz_sg3", sg_out, 8'hFF);
        wait_pos(2, 5); check("lz_sg2", sg_out, 8'h7F);
        wait_pos(1, 5); check("lz_sg1", sg_out, 8'hFF);
        wait_pos(0, 5); check("lz_sg0", sg_out, 8'h92);

        // PWM at half duty
        brightness = 2'd1;
        count_lit(1, lit);
        check("pwm_half", lit, 8);
        wait_pos(1, 7); check("pwm_s7", an_out, 4'b1101);
        wait_pos(1, 8); check("pwm_s8", an_out, 4'hF);
        brightness = 2'd0;
        count_lit(1, lit);
        check("pwm_min", lit, 4);
        brightness = 2'd3;

        // live enable
        en_in = 4'b1011;
        count_lit(2, lit);
        check("en_dark2", lit, 0);
        wait_pos(3, 5); check("en_lit3", an_out, 4'b0111);
        en_in = 4'hF;

        // load timing inside the active digit-0 slot
        lz_blank = 1'b0;
        wait_pos(0, 3);
        dig_in = 16'h0007;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        check("ld_n1_sg", sg_out, 8'h92);
        check("ld_n1_an", an_out, 4'b1110);
        @(negedge clk);
        check("ld_n2_sg", sg_out, 8'hF8);
        check("ld_n2_an", an_out, 4'b1110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        check("global_timeout", 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
